// File: rtl/sata_mem_pkg.sv
// sata_mem_pkg: shared MIG command codes, RAM bus widths and write-arbiter FSM states.
package sata_mem_pkg;
    localparam logic [2:0] APP_CMD_WRITE = 3'b000;
    localparam logic [2:0] APP_CMD_READ = 3'b001;
    localparam int RAM_ADDR_BITS = 29;
    localparam int RAM_DATA_BITS = 256;
    typedef enum logic [1:0] {IDLE, ISSUE, ACK} arb_state_t;
endpackage

// File: rtl/ram_write_arbiter.sv
// ram_write_arbiter: two-requester burst-fair write arbiter driving a MIG app interface.
module ram_write_arbiter
    import sata_mem_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic                       clk_ram,
    input  logic                       rst_ram,
    input  logic                       req0_en,
    input  logic [RAM_ADDR_BITS-1:0]   req0_addr,
    input  logic [RAM_DATA_BITS-1:0]   req0_data,
    output logic                       req0_ack,
    input  logic                       req1_en,
    input  logic [RAM_ADDR_BITS-1:0]   req1_addr,
    input  logic [RAM_DATA_BITS-1:0]   req1_data,
    output logic                       req1_ack,
    output logic [RAM_ADDR_BITS-1:0]   app_addr,
    output logic [2:0]                 app_cmd,
    output logic                       app_en,
    output logic [RAM_DATA_BITS-1:0]   app_wdf_data,
    output logic                       app_wdf_end,
    output logic [RAM_DATA_BITS/8-1:0] app_wdf_mask,
    output logic                       app_wdf_wren,
    input  logic                       app_rdy,
    input  logic                       app_wdf_rdy,
    output logic                       grant_id
);
    localparam logic [7:0] MAX_RUN = 8'(MAX_BURST);
    arb_state_t state;
    logic owner;
    logic [7:0] run_count;
    logic own_req, oth_req, keep, win, en_next, wren_next;
    logic [7:0] run_next;
    assign app_cmd = APP_CMD_WRITE;
    assign app_wdf_mask = '0;
    assign app_wdf_end = app_wdf_wren;
    assign grant_id = owner;
    // Owner keeps the RAM until its run hits MAX_RUN, then yields only if the other side waits.
    always_comb begin
        own_req = owner ? req1_en : req0_en;
        oth_req = owner ? req0_en : req1_en;
        keep = own_req && (run_count < MAX_RUN);
        win = (keep || !oth_req) ? owner : ~owner;
        run_next = keep ? run_count + 8'd1 : (oth_req ? 8'd1 : MAX_RUN);
        en_next = app_en && !app_rdy;
        wren_next = app_wdf_wren && !app_wdf_rdy;
    end
    always_ff @(posedge clk_ram) begin
        if (rst_ram) begin
            state <= IDLE;
            owner <= 1'b0;
            run_count <= '0;
            app_addr <= '0;
            app_wdf_data <= '0;
            app_en <= 1'b0;
            app_wdf_wren <= 1'b0;
            req0_ack <= 1'b0;
            req1_ack <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req0_en || req1_en) begin
                    owner <= win;
                    run_count <= run_next;
                    app_addr <= win ? req1_addr : req0_addr;
                    app_wdf_data <= win ? req1_data : req0_data;
                    app_en <= 1'b1;
                    app_wdf_wren <= 1'b1;
                    state <= ISSUE;
                end
                ISSUE: begin
                    app_en <= en_next;
                    app_wdf_wren <= wren_next;
                    if (!en_next && !wren_next) begin
                        req0_ack <= !owner;
                        req1_ack <= owner;
                        state <= ACK;
                    end
                end
                ACK: begin
                    req0_ack <= 1'b0;
                    req1_ack <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_write_arbiter.sv
// tb_ram_write_arbiter: directed scoreboard bench for ram_write_arbiter with MAX_BURST=4.
module tb_ram_write_arbiter;
    import sata_mem_pkg::*;
    typedef struct {
        logic id;
        logic [28:0] addr;
        logic [255:0] data;
    } beat_t;
    logic clk_ram = 0, rst_ram = 1;
    logic req0_en = 0, req1_en = 0, req0_ack, req1_ack;
    logic [28:0] req0_addr = '0, req1_addr = '0, app_addr;
    logic [255:0] req0_data = '0, req1_data = '0, app_wdf_data;
    logic [2:0] app_cmd;
    logic app_en, app_wdf_end, app_wdf_wren, grant_id;
    logic [31:0] app_wdf_mask;
    logic app_rdy = 1, app_wdf_rdy = 1;
    beat_t q0[$], q1[$], exp_q[$];
    beat_t b0[12], b1[12];
    int n_checks = 0, n_fail = 0, ack_cnt = 0, ack_base;
    logic rand_rdy = 0, prev_iss = 0, prev_en = 0, cap_gid = 0;
    logic [28:0] prev_addr = '0, cap_addr = '0;
    logic [255:0] prev_data = '0, cap_data = '0;

    ram_write_arbiter #(.MAX_BURST(4)) dut (
        .clk_ram(clk_ram), .rst_ram(rst_ram),
        .req0_en(req0_en), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ack(req0_ack),
        .req1_en(req1_en), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ack(req1_ack),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_wdf_data(app_wdf_data),
        .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .grant_id(grant_id)
    );

    always #5 clk_ram = ~clk_ram;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] expv);
        n_checks++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic beat_t mk(input logic id, input logic [28:0] addr, input logic [255:0] data);
        beat_t b;
        b.id = id;
        b.addr = addr;
        b.data = data;
        return b;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic drive();
        req0_en = q0.size() != 0;
        req1_en = q1.size() != 0;
        if (req0_en) begin
            req0_addr = q0[0].addr;
            req0_data = q0[0].data;
        end
        if (req1_en) begin
            req1_addr = q1[0].addr;
            req1_data = q1[0].data;
        end
    endtask

    task automatic tick();
        beat_t e;
        @(posedge clk_ram);
        #1;
        if (prev_iss && (app_en || app_wdf_wren)) begin
            check("addr_stable", 256'(app_addr), 256'(prev_addr));
            check("data_stable", app_wdf_data, prev_data);
        end
        if (app_en && !prev_en) begin
            cap_addr = app_addr;
            cap_data = app_wdf_data;
            cap_gid = grant_id;
        end
        if (req0_ack || req1_ack) begin
            ack_cnt++;
            check("ack_overlap", 256'(req0_ack && req1_ack), 256'(0));
            check("ack_expected", 256'(exp_q.size() != 0), 256'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("ack_id", 256'(req1_ack), 256'(e.id));
                check("issue_gid", 256'(cap_gid), 256'(e.id));
                check("issue_addr", 256'(cap_addr), 256'(e.addr));
                check("issue_data", cap_data, e.data);
            end
            if (req0_ack && q0.size() != 0) void'(q0.pop_front());
            if (req1_ack && q1.size() != 0) void'(q1.pop_front());
        end
        prev_iss = app_en || app_wdf_wren;
        prev_en = app_en;
        prev_addr = app_addr;
        prev_data = app_wdf_data;
        if (rand_rdy) begin
            app_rdy = $urandom_range(0, 2) != 0;
            app_wdf_rdy = $urandom_range(0, 2) != 0;
        end
        drive();
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("run_timeout", 256'(n < budget), 256'(1));
        check("scoreboard_empty", 256'(exp_q.size()), 256'(0));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_addr"}, 256'(app_addr), 256'(0));
        check({tag, "_cmd"}, 256'(app_cmd), 256'(0));
        check({tag, "_en"}, 256'(app_en), 256'(0));
        check({tag, "_wdata"}, app_wdf_data, 256'(0));
        check({tag, "_wend"}, 256'(app_wdf_end), 256'(0));
        check({tag, "_mask"}, 256'(app_wdf_mask), 256'(0));
        check({tag, "_wren"}, 256'(app_wdf_wren), 256'(0));
        check({tag, "_ack0"}, 256'(req0_ack), 256'(0));
        check({tag, "_ack1"}, 256'(req1_ack), 256'(0));
        check({tag, "_gid"}, 256'(grant_id), 256'(0));
    endtask

    initial begin
        beat_t b;
        drive();
        repeat (3) tick();
        check_zero("reset");
        rst_ram = 0;
        tick();
        // single req0 beat with both channels ready
        b = mk(0, 29'h100, {8{32'hA5A5A5A5}});
        q0.push_back(b);
        exp_q.push_back(b);
        drive();
        tick();
        check("t1_en", 256'(app_en), 256'(1));
        check("t1_wren", 256'(app_wdf_wren), 256'(1));
        check("t1_wend", 256'(app_wdf_end), 256'(1));
        check("t1_addr", 256'(app_addr), 256'h100);
        check("t1_ack_early", 256'(req0_ack), 256'(0));
        tick();
        check("t1_en_clr", 256'(app_en), 256'(0));
        check("t1_ack", 256'(req0_ack), 256'(1));
        tick();
        check("t1_ack_once", 256'(req0_ack), 256'(0));
        // contention with MAX_BURST=4 starting from reset
        rst_ram = 1;
        tick();
        rst_ram = 0;
        for (int i = 0; i < 12; i++) begin
            b0[i] = mk(0, 29'h1000 + 29'(i), rnd256());
            b1[i] = mk(1, 29'h2000 + 29'(i), rnd256());
            q0.push_back(b0[i]);
            q1.push_back(b1[i]);
        end
        for (int k = 0; k < 24; k++)
            exp_q.push_back(((k / 4) % 2) != 0 ? b1[(k / 8) * 4 + k % 4] : b0[(k / 8) * 4 + k % 4]);
        ack_base = ack_cnt;
        drive();
        run_until_done(500);
        check("burst_acks", 256'(ack_cnt - ack_base), 256'(24));
        tick();
        // command channel stalled, then data channel stalled
        for (int sw = 0; sw < 2; sw++) begin
            app_rdy = sw != 0;
            app_wdf_rdy = sw == 0;
            b = mk(0, 29'h300 + 29'(sw), rnd256());
            q0.push_back(b);
            exp_q.push_back(b);
            drive();
            for (int i = 1; i <= 6; i++) begin
                tick();
                check(sw != 0 ? "stall_wren_held" : "stall_en_held", 256'(sw != 0 ? app_wdf_wren : app_en), 256'(1));
                check(sw != 0 ? "stall_en_drop" : "stall_wren_drop", 256'(sw != 0 ? app_en : app_wdf_wren), 256'(i == 1));
                check("stall_no_ack", 256'(req0_ack), 256'(0));
            end
            app_rdy = 1;
            app_wdf_rdy = 1;
            tick();
            check("stall_ack", 256'(req0_ack), 256'(1));
            check("stall_en_clr", 256'(app_en || app_wdf_wren), 256'(0));
            tick();
            check("stall_ack_once", 256'(req0_ack), 256'(0));
        end
        // reset while in ISSUE abandons the beat
        app_rdy = 0;
        q0.push_back(mk(0, 29'h400, rnd256()));
        drive();
        tick();
        check("rst_issue_en", 256'(app_en), 256'(1));
        rst_ram = 1;
        q0.delete();
        drive();
        tick();
        check_zero("midrst");
        rst_ram = 0;
        app_rdy = 1;
        tick();
        check("midrst_no_ack", 256'(req0_ack || req1_ack), 256'(0));
        b = mk(1, 29'h500, rnd256());
        q1.push_back(b);
        exp_q.push_back(b);
        ack_base = ack_cnt;
        drive();
        run_until_done(20);
        check("midrst_req1_acks", 256'(ack_cnt - ack_base), 256'(1));
        // req1 streaming under random back-pressure
        for (int i = 0; i < 20; i++) begin
            b = mk(1, 29'($urandom), rnd256());
            q1.push_back(b);
            exp_q.push_back(b);
        end
        ack_base = ack_cnt;
        rand_rdy = 1;
        drive();
        run_until_done(2000);
        rand_rdy = 0;
        app_rdy = 1;
        app_wdf_rdy = 1;
        check("random_acks", 256'(ack_cnt - ack_base), 256'(20));
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_write_arbiter.md
RAM_WRITE_ARBITER -- requirements
Module: ram_write_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 8, max consecutive grants to one requester while the other is waiting (range 1..255).
REQ-002 SHALL have port clk_ram  in  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst_ram  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req0_en / req1_en  in  1  write request, held until ack.
REQ-005 SHALL have ports req0_addr / req1_addr  in  29  MIG app address, stable while en high.
REQ-006 SHALL have ports req0_data / req1_data  in  256  one write beat, stable while en high.
REQ-007 SHALL have ports req0_ack / req1_ack  out  1  single-cycle pulse: beat fully accepted by MIG.
REQ-008 SHALL have ports app_addr out 29, app_cmd out 3, app_en out 1  MIG command channel.
REQ-009 SHALL have ports app_wdf_data out 256, app_wdf_end out 1, app_wdf_mask out 32, app_wdf_wren out 1  MIG write-data channel.
REQ-010 SHALL have ports app_rdy in 1, app_wdf_rdy in 1  MIG flow control.
REQ-011 SHALL have port grant_id  out  1  requester currently owning the MIG (debug).

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, ACK.
REQ-013 SHALL, in IDLE with any req*_en high, latch the winner's addr/data into app_addr/app_wdf_data and enter ISSUE with app_en=1 and app_wdf_wren=1 on the next cycle (1-cycle request-to-issue latency).
REQ-014 SHALL drive app_cmd=3'b000 (write), app_wdf_end=app_wdf_wren, and app_wdf_mask=0 at all times.
REQ-015 SHALL track command and data acceptance independently: app_en clears the cycle after app_en&app_rdy is sampled; app_wdf_wren clears the cycle after app_wdf_wren&app_wdf_rdy is sampled; either order and simultaneous acceptance are legal.
REQ-016 SHALL keep app_addr and app_wdf_data stable throughout ISSUE.
REQ-017 SHALL enter ACK the cycle after both channels are accepted, assert the owner's req*_ack for exactly that one cycle, and return to IDLE.
REQ-018 SHALL ignore req*_en in ACK; the next arbitration occurs in IDLE, giving a minimum of 3 cycles per beat.
REQ-019 SHALL arbitrate as follows: if the owner requests and run_count<MAX_BURST, grant the owner and increment run_count; else if the non-owner requests, switch owner and set run_count=1; else grant the owner and saturate run_count at MAX_BURST.
REQ-020 SHALL, with the other requester idle, let one requester stream indefinitely.
REQ-021 SHALL never assert both acks in the same cycle, and never ack a requester without a completed MIG transaction.
REQ-022 SHALL take no action on stall: unbounded app_rdy/app_wdf_rdy low holds ISSUE with outputs stable; no timeout.

Reset
REQ-023 SHALL, while rst_ram is high, force state=IDLE, owner=0, run_count=0, and all outputs to 0 (app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_mask, app_wdf_wren, acks, grant_id).
REQ-024 SHALL, on reset asserted mid-ISSUE or mid-ACK, abandon the transaction with no ack pulse emitted after reset is sampled.
REQ-025 SHALL make the first request after reset, under contention, go to requester 0.

Structure
REQ-026 SHALL take APP_CMD_WRITE, APP_CMD_READ, RAM_ADDR_BITS=29, RAM_DATA_BITS=256, and the FSM state enum from shared package sata_mem_pkg.
REQ-027 SHALL be a single flat module with no sub-modules; the arbitration decision is inline combinational logic.

Verification
REQ-028 SHALL cover: req0 only, addr=0x100, data=0xA5 pattern, rdy signals high -> app_en/app_wdf_wren high for 1 cycle one cycle after request, req0_ack pulse 2 cycles later, app_addr=0x100.
REQ-029 SHALL cover: both requesting continuously, MAX_BURST=4 -> grants 0,0,0,0,1,1,1,1,0..., acks never overlapping.
REQ-030 SHALL cover: app_wdf_rdy high, app_rdy low for 5 cycles -> app_wdf_wren drops after 1 cycle, app_en held 6 cycles, single ack after app_rdy accept; repeat with the roles of app_rdy and app_wdf_rdy swapped.
REQ-031 SHALL cover: rst_ram pulsed while in ISSUE -> all outputs 0 next cycle, no ack; the following request from req1 completes normally.
REQ-032 SHALL cover: req1 only, 20 beats with random rdy stalls -> 20 acks, app_addr/app_wdf_data sequence matching stimulus, stable during stalls (assertion).
